// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus scheduler:
// FSM state enum, LCD command bytes, power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT_SETUP,
    ST_INIT_E,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_WAIT
  } state_t;

  localparam logic [7:0] LCD_WAKE       = 8'h30;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_HOME       = 8'h02;
  localparam logic [7:0] LCD_HOME_ALT   = 8'h03;
  localparam logic [7:0] LCD_FUNC_8B2L  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;
  localparam logic [7:0] LCD_DDRAM_ROW0 = 8'h80;
  localparam logic [7:0] LCD_DDRAM_ROW1 = 8'hC0;

  localparam int INIT_LEN = 7;
  localparam int IDX_W    = $clog2(INIT_LEN);

  // Entry 0 is the rightmost element.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    LCD_ENTRY_INC,
    LCD_CLEAR,
    LCD_DISP_ON,
    LCD_FUNC_8B2L,
    LCD_WAKE,
    LCD_WAKE,
    LCD_WAKE
  };

  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and home commands need the long execution wait.
  function automatic logic is_clr_cmd(logic rs, logic [7:0] d);
    return !rs && (d == LCD_CLEAR || d == LCD_HOME ||
                   d == LCD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter for the LCD bus requesters.
// Ports: valid[1:0] in, advance in (transfer taken), grant[1:0] out.
module lcd_rr_arbiter
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1: requester 1 wins the next tie.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit bus owner: power-up init, then round-robin writes
// from req0/req1 with setup, E pulse and command wait timing.
// Ports: clk, rst (async, active-low), reqN_valid/rs/data/ready,
//   lcd_rs, lcd_rw (tied 0), lcd_e, lcd_data, init_done, busy.
// Option: LCD_WRAP_EN adds row/col tracking and inserts a DDRAM
//   address command after the last column of a line.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750_000,
  parameter int T_INIT1   = 205_000,
  parameter int T_INIT2   = 5_000,
  parameter int T_AS      = 5,
  parameter int T_EPW     = 25,
  parameter int T_CMD     = 2_500,
  parameter int T_CLR     = 100_000,
  parameter int COLS      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int T_MAX = max_of(
    max_of(max_of(T_POWERUP, T_INIT1), max_of(T_INIT2, T_AS)),
    max_of(max_of(T_EPW, T_CMD), T_CLR));
  localparam int CNT_W = $clog2(T_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // The DDRAM address command carries a 4-bit column.
  if (COLS < 2 || COLS > 16) begin : g_cols_chk
    $error("COLS must be 2..16");
  end

  // A phase of n cycles loads n-1 and ends on the zero count.
  function automatic cnt_t ld(int t);
    return cnt_t'(t - 1);
  endfunction

  function automatic cnt_t init_wait(logic [IDX_W-1:0] i);
    cnt_t w;
    case (i)
      IDX_W'(0): w = ld(T_INIT1);
      IDX_W'(1): w = ld(T_INIT2);
      IDX_W'(5): w = ld(T_CLR);
      default:   w = ld(T_CMD);
    endcase
    return w;
  endfunction

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [7:0]       lcd_data_q, lcd_data_d;
  logic             init_done_q, init_done_d;

`ifdef LCD_WRAP_EN
  localparam int COL_W = $clog2(COLS);
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             ins_q, ins_d;
`endif

  logic [1:0] grant;
  logic       accept;
  logic       cnt_zero;
  logic       sel_rs;
  logic [7:0] sel_data;

  lcd_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == ST_IDLE) && init_done_q && (|grant);

  always_comb begin
    sel_rs   = 1'b0;
    sel_data = '0;
    unique case (1'b1)
      grant[0]: begin
        sel_rs   = req0_rs;
        sel_data = req0_data;
      end
      grant[1]: begin
        sel_rs   = req1_rs;
        sel_data = req1_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_POWERUP;
      cnt_q       <= ld(T_POWERUP);
      idx_q       <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
      init_done_q <= 1'b0;
`ifdef LCD_WRAP_EN
      row_q       <= 1'b0;
      col_q       <= '0;
      ins_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      init_done_q <= init_done_d;
`ifdef LCD_WRAP_EN
      row_q       <= row_d;
      col_q       <= col_d;
      ins_q       <= ins_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero ? cnt_q : cnt_q - 1'b1;
    idx_d       = idx_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    init_done_d = init_done_q;
`ifdef LCD_WRAP_EN
    row_d       = row_q;
    col_d       = col_q;
    ins_d       = ins_q;
`endif
    case (state_q)
      ST_POWERUP: begin
        if (cnt_zero) begin
          state_d    = ST_INIT_SETUP;
          cnt_d      = ld(T_AS);
          lcd_rs_d   = 1'b0;
          lcd_data_d = INIT_ROM[idx_q];
        end
      end
      ST_INIT_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_INIT_E;
          cnt_d   = ld(T_EPW);
        end
      end
      ST_INIT_E: begin
        if (cnt_zero) begin
          state_d = ST_INIT_WAIT;
          cnt_d   = init_wait(idx_q);
        end
      end
      ST_INIT_WAIT: begin
        if (cnt_zero) begin
          if (idx_q == IDX_W'(INIT_LEN - 1)) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d      = idx_q + 1'b1;
            state_d    = ST_INIT_SETUP;
            cnt_d      = ld(T_AS);
            lcd_data_d = INIT_ROM[idx_q + 1'b1];
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SETUP;
          cnt_d      = ld(T_AS);
          lcd_rs_d   = sel_rs;
          lcd_data_d = sel_data;
`ifdef LCD_WRAP_EN
          if (sel_rs) begin
            if (col_q == COL_W'(COLS - 1)) begin
              col_d = '0;
              row_d = ~row_q;
              ins_d = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (is_clr_cmd(1'b0, sel_data)) begin
            row_d = 1'b0;
            col_d = '0;
          end else if (sel_data[7]) begin
            row_d = sel_data[6];
            col_d = COL_W'(sel_data[3:0]);
          end
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_E_HIGH;
          cnt_d   = ld(T_EPW);
        end
      end
      ST_E_HIGH: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = is_clr_cmd(lcd_rs_q, lcd_data_q) ?
                    ld(T_CLR) : ld(T_CMD);
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
`ifdef LCD_WRAP_EN
          // Row already flipped at accept: row 1 means
          // the cursor must move to the second line.
          if (ins_q) begin
            ins_d      = 1'b0;
            state_d    = ST_SETUP;
            cnt_d      = ld(T_AS);
            lcd_rs_d   = 1'b0;
            lcd_data_d = row_q ? LCD_DDRAM_ROW1
                               : LCD_DDRAM_ROW0;
          end
`endif
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  always_comb begin
    lcd_e      = (state_q == ST_INIT_E) ||
                 (state_q == ST_E_HIGH);
    busy       = (state_q != ST_IDLE);
    req0_ready = accept && grant[0];
    req1_ready = accept && grant[1];
  end

  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = lcd_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: timeline model of bus operations
// checked every cycle, plus literal checks of the main scenarios.
module tb_lcd_bus_scheduler;

  localparam int T_POWERUP = 50;
  localparam int T_INIT1   = 20;
  localparam int T_INIT2   = 10;
  localparam int T_AS      = 2;
  localparam int T_EPW     = 4;
  localparam int T_CMD     = 8;
  localparam int T_CLR     = 30;
  localparam int COLS      = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, busy;
  logic [7:0] lcd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  lcd_bus_scheduler #(
    .T_POWERUP (T_POWERUP),
    .T_INIT1   (T_INIT1),
    .T_INIT2   (T_INIT2),
    .T_AS      (T_AS),
    .T_EPW     (T_EPW),
    .T_CMD     (T_CMD),
    .T_CLR     (T_CLR),
    .COLS      (COLS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .busy       (busy)
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ---------------- model ----------------
  // A bus operation starts its setup at cycle s; E is high for
  // [s+T_AS, s+T_AS+T_EPW); the bus is busy until that plus w.
  typedef struct {
    int         s;
    bit         rs;
    logic [7:0] d;
    int         w;
  } op_t;

  op_t ops[$];
  int  m_init_end;
  int  m_prio;
  int  m_row, m_col;
  int  rom_d[7] = '{'h30, 'h30, 'h30, 'h38, 'h0C, 'h01, 'h06};
  int  rom_w[7] = '{T_INIT1, T_INIT2, T_CMD, T_CMD, T_CMD,
                    T_CLR, T_CMD};

  function automatic int op_len(int w);
    return T_AS + T_EPW + w;
  endfunction

  function automatic int wait_of(bit rs, logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
      return T_CLR;
    return T_CMD;
  endfunction

  function automatic void model_reset();
    int s;
    op_t o;
    ops.delete();
    s = T_POWERUP;
    for (int k = 0; k < 7; k++) begin
      o.s = s; o.rs = 0; o.d = rom_d[k][7:0]; o.w = rom_w[k];
      ops.push_back(o);
      s += op_len(rom_w[k]);
    end
    m_init_end = s;
    m_prio = 0;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_accept(int c, bit rs,
                                       logic [7:0] d);
    op_t o;
    o.s = c + 1; o.rs = rs; o.d = d; o.w = wait_of(rs, d);
    ops.push_back(o);
`ifdef LCD_WRAP_EN
    if (rs) begin
      if (m_col == COLS - 1) begin
        op_t n;
        n.s  = o.s + op_len(o.w);
        n.rs = 0;
        n.d  = (m_row == 0) ? 8'hC0 : 8'h80;
        n.w  = T_CMD;
        ops.push_back(n);
        m_row = 1 - m_row;
        m_col = 0;
      end else begin
        m_col++;
      end
    end else if (d == 8'h01 || d == 8'h02 || d == 8'h03) begin
      m_row = 0;
      m_col = 0;
    end else if (d[7]) begin
      m_row = d[6];
      m_col = d[3:0];
    end
`endif
  endfunction

  always @(negedge clk) begin
    int  c;
    bit  in_op, e_x, idone, idle, g0, g1;
    op_t cur;
    if (!rst) begin
      model_reset();
    end else begin
      c = cyc;
      while (ops.size() > 1 && ops[1].s <= c) void'(ops.pop_front());
      cur   = ops[0];
      in_op = c >= cur.s && c < cur.s + op_len(cur.w);
      e_x   = c >= cur.s + T_AS && c < cur.s + T_AS + T_EPW;
      idone = c >= m_init_end;
      idle  = idone && !in_op;
      g0 = idle && req0_valid && (!req1_valid || m_prio == 0);
      g1 = idle && req1_valid && (!req0_valid || m_prio == 1);
      chk("m_e", lcd_e, e_x);
      chk("m_rw", lcd_rw, 0);
      chk("m_rs", lcd_rs, (c >= cur.s) ? cur.rs : 1'b0);
      chk("m_data", lcd_data, (c >= cur.s) ? cur.d : 8'h00);
      chk("m_busy", busy, !idle);
      chk("m_init_done", init_done, idone);
      chk("m_ready0", req0_ready, g0);
      chk("m_ready1", req1_ready, g1);
      if (g0) begin
        model_accept(c, req0_rs, req0_data);
        m_prio = 1;
      end else if (g1) begin
        model_accept(c, req1_rs, req1_data);
        m_prio = 0;
      end
    end
  end

  // ---------------- bus observer ----------------
  int         rise_c[$], fall_c[$];
  logic [7:0] rise_d[$];
  bit         rise_rs[$];
  int         id_rise_c;
  logic       prev_e, prev_id;

  always @(negedge clk) begin
    if (!rst) begin
      rise_c.delete(); fall_c.delete();
      rise_d.delete(); rise_rs.delete();
      id_rise_c = -1;
      prev_e = 0; prev_id = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        rise_c.push_back(cyc);
        rise_d.push_back(lcd_data);
        rise_rs.push_back(lcd_rs);
      end
      if (!lcd_e && prev_e) fall_c.push_back(cyc);
      if (init_done && !prev_id) id_rise_c = cyc;
      prev_e = lcd_e;
      prev_id = init_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cond(input int sel, input int budget,
                           output int c);
    bit hit;
    hit = 0;
    c = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = req0_ready;
        1: hit = req1_ready;
        2: hit = lcd_e;
        3: hit = !lcd_e;
        4: hit = !busy;
        6: hit = req0_ready || req1_ready;
        default: hit = init_done;
      endcase
      if (hit) c = cyc;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL timeout sel=%0d got=none want=event", sel);
    end
  endtask

  task automatic check_init();
    int exp_d[7] = '{'h30, 'h30, 'h30, 'h38, 'h0C, 'h01, 'h06};
    int exp_g[7] = '{20, 10, 8, 8, 8, 30, 8};
    int nxt;
    #1;
    chk("init_pulses", rise_c.size(), 7);
    if (rise_c.size() >= 7 && fall_c.size() >= 7) begin
      chk("init_first_e", rise_c[0], 52);
      for (int k = 0; k < 7; k++) begin
        chk("init_data", rise_d[k], exp_d[k]);
        chk("init_rs", rise_rs[k], 0);
        nxt = (k < 6) ? rise_c[k+1] - T_AS : id_rise_c;
        chk("init_gap", nxt - fall_c[k], exp_g[k]);
      end
    end
    chk("init_busy", busy, 0);
  endtask

  int t, t1, t2, t3, n0;
  int who[4];
  int acc[17];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // 1: power-up init
    wait_cond(5, 400, t);
    check_init();

    // 2: single data write
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_data = 8'h41;
    wait_cond(0, 100, t);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("t2_rs", lcd_rs, 1);
    chk("t2_data", lcd_data, 8'h41);
    wait_cond(2, 50, t1);
    chk("t2_e_rise", t1 - t, 3);
    wait_cond(3, 50, t1);
    chk("t2_e_fall", t1 - t, 7);
    wait_cond(4, 50, t1);
    chk("t2_idle", t1 - t, 15);

    // 4: clear vs normal command wait
    @(posedge clk); #1;
    req1_valid = 1; req1_rs = 0; req1_data = 8'h01;
    wait_cond(1, 100, t1);
    @(posedge clk); #1;
    req1_data = 8'h0C;
    wait_cond(1, 100, t2);
    chk("t4_clr_gap", t2 - t1, 37);
    @(posedge clk); #1;
    req1_data = 8'h06;
    wait_cond(1, 100, t3);
    chk("t4_cmd_gap", t3 - t2, 15);
    @(posedge clk); #1;
    req1_valid = 0;
    wait_cond(4, 100, t);

    // 3: both requesters contending
    #1 n0 = rise_d.size();
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_data = 8'h50;
    req1_valid = 1; req1_rs = 1; req1_data = 8'h60;
    for (int k = 0; k < 4; k++) begin
      wait_cond(6, 100, t);
      who[k] = req1_ready ? 1 : 0;
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0;
    wait_cond(4, 100, t);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", who[k], k % 2);
      if (rise_d.size() > n0 + k)
        chk("t3_bus", rise_d[n0+k], (k % 2) ? 8'h60 : 8'h50);
    end
    chk("t3_pulses", rise_d.size() - n0, 4);

    // 5: reset during E high
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_data = 8'h42;
    wait_cond(0, 100, t);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_cond(2, 50, t);
    @(posedge clk); #1;
    chk("t5_pre_e", lcd_e, 1);
    rst = 0;
    #1;
    chk("t5_rst_e", lcd_e, 0);
    chk("t5_rst_data", lcd_data, 0);
    chk("t5_rst_rs", lcd_rs, 0);
    chk("t5_rst_busy", busy, 1);
    chk("t5_rst_idone", init_done, 0);
    chk("t5_rst_ready", {req1_ready, req0_ready}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    wait_cond(5, 400, t);
    check_init();

    // 6: sixteen characters then one more
    #1 n0 = rise_d.size();
    @(posedge clk); #1;
    req0_valid = 1; req0_rs = 1; req0_data = 8'h41;
    for (int i = 0; i < 17; i++) begin
      wait_cond(0, 100, acc[i]);
      @(posedge clk); #1;
      req0_data = 8'h42 + 8'(i);
    end
    req0_valid = 0;
    wait_cond(4, 100, t);
    #1;
`ifdef LCD_WRAP_EN
    chk("t6_gap", acc[16] - acc[15], 29);
    if (rise_d.size() > n0 + 16) begin
      chk("t6_ins_data", rise_d[n0+16], 8'hC0);
      chk("t6_ins_rs", rise_rs[n0+16], 0);
    end
    chk("t6_pulses", rise_d.size() - n0, 18);
`else
    chk("t6_gap", acc[16] - acc[15], 15);
    if (rise_d.size() > n0 + 16) begin
      chk("t6_17th_data", rise_d[n0+16], 8'h51);
      chk("t6_17th_rs", rise_rs[n0+16], 1);
    end
    chk("t6_pulses", rise_d.size() - n0, 17);
`endif

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
